comparator_serial: RTL and testbench

- Multi-cycle magnitude comparator for two WIDTH-bit operands. It scans SLICE bits per clock, MSB slice first, with a start/done handshake.
- Supports unsigned or two's-complement signed mode, selected per operation.
- Keeps the LT/EQ/GT cascade-input convention of the existing combinational comparators, so wide compares can be chained or resolved against an upstream result.
- Sits where wide compares would otherwise create a long combinational path.

---
 rtl/comparator_serial.sv | 152 +++++++++++++++
 tb/tb_comparator_serial.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial.sv
// Multi-cycle magnitude comparator: scans SLICE bits per clock, MSB slice first,
// with LT/EQ/GT cascade inputs resolving fully-equal operands.
module comparator_serial #(
    parameter int WIDTH      = 16,
    parameter int SLICE      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             LTin,
    input  logic             EQ_in,
    input  logic             GTin,
    output logic             busy,
    output logic             done,
    output logic             LTout,
    output logic             EQout,
    output logic             GTout
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    generate
        if (WIDTH <= 0 || SLICE <= 0 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("comparator_serial: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic [KW-1:0]    k_q;
    logic             found_q, dlt_q;
    logic             lt_in_q, eq_in_q, gt_in_q;
    logic             lt_q, eq_q, gt_q;

    logic [SLICE-1:0] a_sl, b_sl;
    logic             differ, slice_lt, last, scan_end, accept;
    logic [2:0]       casc_res, res_d;

    // Operands shift left each cycle, so the slice under test is always on top.
    assign a_sl     = a_q[WIDTH-1 -: SLICE];
    assign b_sl     = b_q[WIDTH-1 -: SLICE];
    assign differ   = (a_sl != b_sl);
    assign slice_lt = (a_sl < b_sl);
    assign last     = (k_q == KW'(N - 1));
    assign scan_end = last || ((EARLY_EXIT != 0) && differ);
    assign accept   = start && (state_q != S_COMPARE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_COMPARE;
            S_COMPARE: if (scan_end) state_d = S_DONE;
            S_DONE:    state_d = accept ? S_COMPARE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_COMPARE: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    // Cascade priority: GT over LT; EQ_in never overrides, all-zero gives EQ.
    always_comb begin
        casez ({gt_in_q, lt_in_q, eq_in_q})
            3'b1??:  casc_res = RES_GT;
            3'b01?:  casc_res = RES_LT;
            default: casc_res = RES_EQ;
        endcase
    end

    always_comb begin
        res_d = casc_res;
        if (found_q)     res_d = dlt_q ? RES_LT : RES_GT;
        else if (differ) res_d = slice_lt ? RES_LT : RES_GT;
    end

    // Flipping both sign bits turns a signed compare into an unsigned one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            found_q <= 1'b0;
            dlt_q   <= 1'b0;
            lt_in_q <= 1'b0;
            eq_in_q <= 1'b0;
            gt_in_q <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= A ^ (signed_mode ? MSB_MASK : '0);
            b_q     <= B ^ (signed_mode ? MSB_MASK : '0);
            k_q     <= '0;
            found_q <= 1'b0;
            dlt_q   <= 1'b0;
            lt_in_q <= LTin;
            eq_in_q <= EQ_in;
            gt_in_q <= GTin;
        end else if (state_q == S_COMPARE) begin
            a_q <= a_q << SLICE;
            b_q <= b_q << SLICE;
            k_q <= k_q + KW'(1);
            if (!found_q && differ) begin
                found_q <= 1'b1;
                dlt_q   <= slice_lt;
            end
            if (scan_end) {lt_q, eq_q, gt_q} <= res_d;
        end
    end

    assign LTout = lt_q;
    assign EQout = eq_q;
    assign GTout = gt_q;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
    a_done_onehot:    assert property (@(posedge clk) disable iff (!rst_n)
                                       done |-> $onehot({lt_q, eq_q, gt_q}));

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial: an early-exit and a constant-latency
// instance checked every cycle against an arithmetic reference model.
module tb_comparator_serial;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    logic          clk = 1'b0;
    logic          rst_n, start, signed_mode, LTin, EQ_in, GTin;
    logic [W-1:0]  A, B;
    logic [1:0]    busy, done, lto, eqo, gto;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model state per instance: 0 = early exit, 1 = constant latency
    bit       m_busy [2];
    bit       m_done [2];
    logic [2:0] m_res  [2];
    logic [2:0] m_pend [2];
    int       m_left [2];

    comparator_serial #(.WIDTH(W), .SLICE(S), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .LTin(LTin), .EQ_in(EQ_in), .GTin(GTin),
        .busy(busy[0]), .done(done[0]), .LTout(lto[0]), .EQout(eqo[0]), .GTout(gto[0]));

    comparator_serial #(.WIDTH(W), .SLICE(S), .EARLY_EXIT(0)) dut_cl (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .LTin(LTin), .EQ_in(EQ_in), .GTin(GTin),
        .busy(busy[1]), .done(done[1]), .LTout(lto[1]), .EQout(eqo[1]), .GTout(gto[1]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {LT,EQ,GT} from plain arithmetic, cascade applied when operands match
    function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit sm, input bit lt, input bit gt);
        bit less, greater;
        less    = sm ? ($signed(a) < $signed(b)) : (a < b);
        greater = sm ? ($signed(a) > $signed(b)) : (a > b);
        if (less)    return 3'b100;
        if (greater) return 3'b001;
        if (gt)      return 3'b001;
        if (lt)      return 3'b100;
        return 3'b010;
    endfunction

    // index of the first differing slice counted from the MSB, N when equal
    function automatic int first_slice(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        for (int i = W - 1; i >= 0; i--)
            if (x[i]) return (W - 1 - i) / S;
        return N;
    endfunction

    task automatic model_step();
        int fs;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] = 0; m_done[i] = 0; m_res[i] = 3'b000; m_left[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_busy[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_busy[i] = 0; m_done[i] = 1; m_res[i] = m_pend[i];
                    end
                end else if (start) begin
                    m_pend[i] = ref_res(A, B, signed_mode, LTin, GTin);
                    fs        = first_slice(A, B);
                    m_left[i] = (i == 0 && fs < N) ? fs + 1 : N;
                    m_busy[i] = 1;
                end
            end
        end
    endtask

    // one clock: model advances on the edge, DUTs are compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++)
            chk($sformatf("cycle%0d_dut%0d", cyc, i),
                {27'd0, busy[i], done[i], lto[i], eqo[i], gto[i]},
                {27'd0, m_busy[i], m_done[i], m_res[i]});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy != 2'b00 && n < 20) begin tick(); n++; end
        chk("drain_timeout", {31'd0, busy != 2'b00}, 32'd0);
    endtask

    // start at cycle T, expect done of instance sel in cycle T+exp_lat
    task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sm, input bit lt, input bit eq, input bit gt,
                       input int sel, input int exp_lat, input logic [2:0] exp_r);
        int n;
        A = a; B = b; signed_mode = sm; LTin = lt; EQ_in = eq; GTin = gt; start = 1'b1;
        tick();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); signed_mode = 1'($urandom);
        LTin = 1'($urandom); EQ_in = 1'($urandom); GTin = 1'($urandom);
        n = 1;
        while (!done[sel] && n < 40) begin tick(); n++; end
        chk({nm, "_timeout"}, {31'd0, done[sel]}, 32'd1);
        chk({nm, "_lat"}, n, exp_lat);
        chk({nm, "_res"}, {29'd0, lto[sel], eqo[sel], gto[sel]}, {29'd0, exp_r});
        chk({nm, "_model"}, {29'd0, m_res[sel]}, {29'd0, exp_r});
        drain();
    endtask

    initial begin
        int n, dsum;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0;
        LTin = 1'b0; EQ_in = 1'b0; GTin = 1'b0; A = '0; B = '0;
        @(negedge clk);
        tick(); tick();
        chk("reset_state", {22'd0, busy, done, lto, eqo, gto}, 32'd0);
        rst_n = 1'b1;
        tick();

        run("unsigned_ee",   16'h1234, 16'h1334, 0, 0, 0, 0, 0, 3, 3'b100);
        run("unsigned_cl",   16'h1234, 16'h1334, 0, 0, 0, 0, 1, 5, 3'b100);
        run("casc_gt_lt",    16'hBEEF, 16'hBEEF, 0, 1, 0, 1, 0, 5, 3'b001);
        run("casc_lt",       16'hBEEF, 16'hBEEF, 0, 1, 0, 0, 0, 5, 3'b100);
        run("casc_zero",     16'hBEEF, 16'hBEEF, 0, 0, 0, 0, 0, 5, 3'b010);
        run("casc_eq_only",  16'hBEEF, 16'hBEEF, 1, 0, 1, 0, 0, 5, 3'b010);
        run("signed_neg",    16'h8000, 16'h0001, 1, 0, 0, 0, 0, 2, 3'b100);
        run("unsigned_big",  16'h8000, 16'h0001, 0, 0, 0, 0, 0, 2, 3'b001);
        run("const_lat",     16'hF000, 16'h0000, 0, 0, 0, 0, 1, 5, 3'b001);
        run("early_lat",     16'hF000, 16'h0000, 0, 0, 0, 0, 0, 2, 3'b001);
        run("signed_m1",     16'hFFFF, 16'h0001, 1, 0, 0, 1, 0, 2, 3'b100);
        run("signed_lsb",    16'hFFFE, 16'hFFFF, 1, 0, 0, 1, 0, 5, 3'b100);
        run("unsigned_gt",   16'h00A5, 16'h00A4, 0, 1, 0, 0, 0, 5, 3'b001);

        // start pulsed while busy with different operands must be ignored
        A = 16'h1234; B = 16'h1334; signed_mode = 0; LTin = 0; EQ_in = 0; GTin = 0; start = 1'b1;
        tick();
        A = 16'hFFFF; B = 16'h0000; GTin = 1'b1;
        tick();
        start = 1'b0;
        n = 2;
        while (!done[0] && n < 40) begin tick(); n++; end
        chk("ignore_lat", n, 3);
        chk("ignore_res", {29'd0, lto[0], eqo[0], gto[0]}, 32'b100);
        drain();

        // start held through DONE: second compare begins the very next cycle
        A = 16'hF000; B = 16'h0000; signed_mode = 0; LTin = 0; EQ_in = 0; GTin = 0; start = 1'b1;
        tick();
        n = 1;
        while (!done[0] && n < 40) begin tick(); n++; end
        chk("b2b_first_lat", n, 2);
        chk("b2b_first_res", {29'd0, lto[0], eqo[0], gto[0]}, 32'b001);
        A = 16'h0005; B = 16'h0007;
        tick();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy[0]}, 32'd1);
        n = 1;
        while (!done[0] && n < 40) begin tick(); n++; end
        chk("b2b_second_lat", n, 5);
        chk("b2b_second_res", {29'd0, lto[0], eqo[0], gto[0]}, 32'b100);
        drain();

        // reset in mid-compare clears everything and no done pulse follows
        A = 16'h1234; B = 16'h1334; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_pre_busy", {30'd0, busy}, 32'b11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid", {22'd0, busy, done, lto, eqo, gto}, 32'd0);
        dsum = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dsum += int'(done[0]) + int'(done[1]);
        end
        chk("rst_no_done", dsum, 0);
        chk("rst_hold_zero", {26'd0, lto, eqo, gto}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
